// File: rtl/axi_periph_pkg.sv
// -----------------------------------------------------------------------------
// axi_periph_pkg
// Shared constants for the AXI-Lite peripheral set. Holds the GPIO register
// map and the GPIO input-conditioning constants.
// No ports (package).
// -----------------------------------------------------------------------------
package axi_periph_pkg;

  // GPIO slave register map (byte offsets within the peripheral window).
  typedef enum logic [4:0] {
    GPIO_REG_DATA       = 5'h00,
    GPIO_REG_DIR        = 5'h04,
    GPIO_REG_IRQ_STATUS = 5'h08,
    GPIO_REG_RISE_EN    = 5'h0C,
    GPIO_REG_FALL_EN    = 5'h10
  } gpio_reg_e;

  // Input conditioning: default debounce depth and synchroniser depth.
  localparam int GPIO_DEBOUNCE_DEFAULT = 4;
  localparam int GPIO_SYNC_STAGES      = 2;

endpackage : axi_periph_pkg

// File: rtl/gpio_bit_debounce.sv
// -----------------------------------------------------------------------------
// gpio_bit_debounce
// Single-bit conditioner: two-flop synchroniser, persistence counter and the
// accepted ("stable") level, plus rise/fall pulses derived from the update.
// Ports:
//   ACLK, ARESET : clock, synchronous active-high reset
//   pad          : asynchronous pad input
//   level        : debounced level (the stable register)
//   rise, fall   : combinational pulses, high in the cycle whose clock edge
//                  moves stable 0->1 / 1->0
// -----------------------------------------------------------------------------
module gpio_bit_debounce
  import axi_periph_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Synchroniser stages are kept as two plain flops with nothing in between
  // so timing tools recognise the metastability chain (GPIO_SYNC_STAGES deep).
  logic                 sync1_reg;
  logic                 sync2_reg;
  logic                 stable_reg;
  logic                 stable_next;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;

  // Any single cycle of agreement restarts the count; acceptance resets it,
  // so the counter never reaches a value it could wrap from.
  always_comb begin
    stable_next = stable_reg;
    cnt_next    = cnt_reg;
    if (sync2_reg == stable_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_MAX) begin
      stable_next = sync2_reg;
      cnt_next    = '0;
    end else begin
      cnt_next = cnt_reg + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg  <= pad;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Edges come from next vs current so the status register in the parent
  // captures the event on the same edge that updates stable.
  assign rise  = stable_next & ~stable_reg;
  assign fall  = ~stable_next & stable_reg;
  assign level = stable_reg;

endmodule : gpio_bit_debounce

// File: rtl/gpio_in_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_in_conditioner
// Conditions asynchronous pad inputs for the GPIO slave: per-bit synchronise
// and debounce, then sticky rise/fall interrupt status with a level irq.
// Ports:
//   ACLK, ARESET : clock, synchronous active-high reset
//   gpio_pad_in  : asynchronous pad inputs
//   gpio_in      : debounced levels for register readback
//   rise_en      : per-bit rising-edge interrupt enable
//   fall_en      : per-bit falling-edge interrupt enable
//   irq_clear    : per-bit write-1-to-clear pulses
//   irq_status   : sticky edge flags
//   irq          : OR of irq_status
// -----------------------------------------------------------------------------
module gpio_in_conditioner
  import axi_periph_pkg::*;
#(
  parameter int GPIO_WIDTH      = 32,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [GPIO_WIDTH-1:0] gpio_pad_in,
  output logic [GPIO_WIDTH-1:0] gpio_in,
  input  logic [GPIO_WIDTH-1:0] rise_en,
  input  logic [GPIO_WIDTH-1:0] fall_en,
  input  logic [GPIO_WIDTH-1:0] irq_clear,
  output logic [GPIO_WIDTH-1:0] irq_status,
  output logic                  irq
);

  logic [GPIO_WIDTH-1:0] level;
  logic [GPIO_WIDTH-1:0] rise_evt;
  logic [GPIO_WIDTH-1:0] fall_evt;
  logic [GPIO_WIDTH-1:0] irq_status_reg;
  logic [GPIO_WIDTH-1:0] irq_status_next;

  generate
    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_bit
      gpio_bit_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
      ) u_debounce (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .pad    (gpio_pad_in[gi]),
        .level  (level[gi]),
        .rise   (rise_evt[gi]),
        .fall   (fall_evt[gi])
      );
    end
  endgenerate

  // Set wins over clear; enables only gate new events, never existing flags.
  always_comb begin
    irq_status_next = ((rise_evt & rise_en) | (fall_evt & fall_en))
                    | (irq_status_reg & ~irq_clear);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_status_reg <= '0;
    end else begin
      irq_status_reg <= irq_status_next;
    end
  end

  assign gpio_in    = level;
  assign irq_status = irq_status_reg;
  assign irq        = |irq_status_reg;

endmodule : gpio_in_conditioner
